// File: rtl/axis_frame_packer_pkg.sv
// Shared types and helpers for the AXI-Stream frame packer.
package axis_frame_packer_pkg;

  localparam int LOG_LEN_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Index of the last sample in a frame of 2^log_len samples.
  function automatic logic [31:0] frame_len_max(input logic [LOG_LEN_WIDTH-1:0] log_len);
    return (32'd1 << log_len) - 32'd1;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid buffer (output register + skid register).
// s_ready comes straight from a flop, so there is no combinational path
// from m_ready back to the upstream stage.
module axis_skid_buffer #(
  parameter int DATA_WIDTH = 33
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  empty
);

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  out_free;
  logic                  push;

  // Output register may be (re)loaded when empty or being popped this cycle.
  assign out_free = !out_valid || m_ready;
  assign push     = s_valid && !skid_valid;

  // Buffer state: skid drains into the output first, otherwise new beats go
  // to the output when it is free or into the skid when the output is stalled.
  always_ff @(posedge aclk or posedge areset) begin
    // NOTE: the data registers are reset as well as the valid flags so the
    // master bus reads zero straight out of reset, not stale contents.
    if (areset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (out_free) begin
      // NOTE: non-blocking assignments keep every flop sampling the
      // pre-edge values, regardless of statement order.
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= push;
        if (push) begin
          out_data <= s_data;
        end
      end
    end else if (push) begin
      skid_valid <= 1'b1;
      skid_data  <= s_data;
    end
  end

  assign s_ready = !skid_valid;
  assign m_valid = out_valid;
  assign m_data  = out_data;
  assign empty   = !out_valid && !skid_valid;

endmodule

// File: rtl/axis_frame_packer.sv
// Frames the decimated sample stream into packets of 2^log_frame_length
// samples, marking the final sample with tlast. Run/stop control always
// stops on a frame boundary; frame_count tallies delivered frames.
module axis_frame_packer
  import axis_frame_packer_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        enable,
  input  logic [LOG_LEN_WIDTH-1:0]    log_frame_length,
  output logic                        busy,
  output logic [31:0]                 frame_count,
  output logic                        S_AXIS_tready,
  input  logic                        S_AXIS_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                        M_AXIS_tready,
  output logic                        M_AXIS_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tlast
);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] index_q;
  logic [31:0] len_max_q;

  logic        buf_s_valid;
  logic        buf_s_ready;
  logic        buf_empty;
  logic        last_beat;
  logic        run_push;
  logic [AXIS_TDATA_WIDTH:0] buf_m_data;

  assign last_beat = (index_q == len_max_q);
  // Only beats accepted while running enter the buffer; IDLE swallows them.
  assign run_push    = (state_q == ST_RUN) && S_AXIS_tvalid && buf_s_ready;
  assign buf_s_valid = (state_q == ST_RUN) && S_AXIS_tvalid;

  axis_skid_buffer #(
    .DATA_WIDTH(AXIS_TDATA_WIDTH + 1)
  ) u_skid (
    .aclk    (aclk),
    .areset  (areset),
    .s_valid (buf_s_valid),
    .s_ready (buf_s_ready),
    .s_data  ({last_beat, S_AXIS_tdata}),
    .m_valid (M_AXIS_tvalid),
    .m_ready (M_AXIS_tready),
    .m_data  (buf_m_data),
    .empty   (buf_empty)
  );

  assign M_AXIS_tlast = buf_m_data[AXIS_TDATA_WIDTH];
  assign M_AXIS_tdata = buf_m_data[AXIS_TDATA_WIDTH-1:0];

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    state_d       = state_q;
    S_AXIS_tready = 1'b0;
    busy          = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        S_AXIS_tready = 1'b1;
        busy          = 1'b0;
        if (enable) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        S_AXIS_tready = buf_s_ready;
        if (run_push && last_beat && !enable) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (buf_empty) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Position within the frame; frame length is latched only at frame start.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      index_q   <= '0;
      len_max_q <= '0;
    end else if ((state_q == ST_IDLE) && enable) begin
      index_q   <= '0;
      len_max_q <= frame_len_max(log_frame_length);
    end else if (run_push) begin
      if (last_beat) begin
        index_q <= '0;
        if (enable) begin
          len_max_q <= frame_len_max(log_frame_length);
        end
      end else begin
        index_q <= index_q + 32'd1;
      end
    end
  end

  // Completed frames: counted on the tlast handshake at the output.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      frame_count <= '0;
    end else if (M_AXIS_tvalid && M_AXIS_tready && M_AXIS_tlast) begin
      frame_count <= frame_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_axis_frame_packer.sv
// Self-checking bench for axis_frame_packer: directed scenarios with random
// data and random output backpressure, checked against a queue-based model.
module tb_axis_frame_packer;

  localparam int W = 32;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          enable = 1'b0;
  logic [4:0]    log_frame_length = '0;
  logic          busy;
  logic [31:0]   frame_count;
  logic          S_AXIS_tready;
  logic          S_AXIS_tvalid = 1'b0;
  logic [W-1:0]  S_AXIS_tdata = '0;
  logic          M_AXIS_tready = 1'b1;
  logic          M_AXIS_tvalid;
  logic [W-1:0]  M_AXIS_tdata;
  logic          M_AXIS_tlast;

  axis_frame_packer #(.AXIS_TDATA_WIDTH(W)) dut (
    .aclk             (aclk),
    .areset           (areset),
    .enable           (enable),
    .log_frame_length (log_frame_length),
    .busy             (busy),
    .frame_count      (frame_count),
    .S_AXIS_tready    (S_AXIS_tready),
    .S_AXIS_tvalid    (S_AXIS_tvalid),
    .S_AXIS_tdata     (S_AXIS_tdata),
    .M_AXIS_tready    (M_AXIS_tready),
    .M_AXIS_tvalid    (M_AXIS_tvalid),
    .M_AXIS_tdata     (M_AXIS_tdata),
    .M_AXIS_tlast     (M_AXIS_tlast)
  );

  typedef struct packed {
    logic         last;
    logic [W-1:0] data;
  } beat_t;

  // Reference model: expected output beats plus frame bookkeeping.
  beat_t           exp_q[$];
  int unsigned     in_cnt = 0;
  int unsigned     out_cnt = 0;
  int unsigned     exp_frames = 0;
  longint unsigned pos = 0;
  longint unsigned cur_len = 1;
  logic            busy_at_last = 1'b0;
  int unsigned     cyc = 0;
  int unsigned     first_in = 0;
  int unsigned     first_out = 0;
  int unsigned     last_out = 0;
  bit              stall_prev = 1'b0;
  logic [W:0]      stall_val = '0;

  bit keep = 1'b1;        // accepted input is expected to appear in frames
  bit chk_ready = 1'b1;   // S_AXIS_tready must equal "fewer than 2 held"
  bit bp_mode = 1'b0;
  bit m_ready_dir = 1'b1;

  int checks = 0;
  int passes = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial forever #5 aclk = ~aclk;

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  // Output-side ready: random when backpressure testing, otherwise directed.
  initial forever begin
    @(posedge aclk);
    #2;
    M_AXIS_tready = bp_mode ? 1'($urandom_range(0, 1)) : m_ready_dir;
  end

  // Monitor and model, sampled mid-cycle.
  initial forever begin
    @(negedge aclk);
    if (areset) begin
      exp_q.delete();
      in_cnt = 0;
      out_cnt = 0;
      exp_frames = 0;
      pos = 0;
      stall_prev = 1'b0;
    end else begin
      automatic bit    in_hs  = S_AXIS_tvalid && S_AXIS_tready;
      automatic bit    out_hs = M_AXIS_tvalid && M_AXIS_tready;
      automatic beat_t e;
      check("m_tvalid_vs_model", M_AXIS_tvalid, exp_q.size() != 0);
      if (chk_ready)
        check("s_tready_vs_fill", S_AXIS_tready, (in_cnt - out_cnt) < 2);
      if (stall_prev)
        check("stall_hold", {M_AXIS_tlast, M_AXIS_tdata}, stall_val);
      if (out_hs && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("m_tdata", M_AXIS_tdata, e.data);
        check("m_tlast", M_AXIS_tlast, e.last);
        if (e.last) begin
          exp_frames++;
          busy_at_last = busy;
        end
        if (out_cnt == 0) first_out = cyc;
        last_out = cyc;
        out_cnt++;
      end
      stall_prev = M_AXIS_tvalid && !M_AXIS_tready;
      stall_val  = {M_AXIS_tlast, M_AXIS_tdata};
      if (in_hs && keep) begin
        if (pos == 0) cur_len = 64'd1 << log_frame_length;
        e.data = S_AXIS_tdata;
        e.last = (pos + 1 == cur_len);
        pos = e.last ? 0 : pos + 1;
        exp_q.push_back(e);
        if (in_cnt == 0) first_in = cyc;
        in_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic send_beat(input logic [W-1:0] d);
    int n = 0;
    S_AXIS_tvalid = 1'b1;
    S_AXIS_tdata  = d;
    @(negedge aclk);
    while (!S_AXIS_tready && n < 200) begin
      n++;
      @(negedge aclk);
    end
    if (n >= 200) check("send_timeout", S_AXIS_tready, 1'b1);
    @(posedge aclk);
    #1;
    S_AXIS_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 500) check("drain_timeout", exp_q.size(), 0);
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  task automatic start_run();
    enable = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    // Reset state.
    check("rst_m_tvalid", M_AXIS_tvalid, 1'b0);
    check("rst_m_tlast", M_AXIS_tlast, 1'b0);
    check("rst_m_tdata", M_AXIS_tdata, '0);
    check("rst_frame_count", frame_count, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_s_tready", S_AXIS_tready, 1'b1);
    areset = 1'b0;

    // Framing: 12 consecutive samples, frames of 4.
    log_frame_length = 5'd2;
    start_run();
    for (int i = 0; i < 12; i++) send_beat(W'(i));
    wait_drain();
    check("frm_frame_count", frame_count, 32'd3);
    check("frm_latency", first_out - first_in, 1);
    check("frm_no_bubbles", last_out - first_out, 11);
    check("frm_busy_run", busy, 1'b1);

    // Backpressure: 64 random samples, random output stalls, frames of 8.
    do_reset();
    log_frame_length = 5'd3;
    bp_mode = 1'b1;
    start_run();
    for (int i = 0; i < 64; i++) begin
      send_beat($urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge aclk);
        #1;
      end
    end
    wait_drain();
    bp_mode = 1'b0;
    check("bp_frame_count", frame_count, 32'd8);
    check("bp_out_cnt", out_cnt, 64);

    // Stop mid-frame: frame of 16 still completes, then IDLE discards input.
    do_reset();
    chk_ready = 1'b0;
    log_frame_length = 5'd4;
    start_run();
    for (int i = 0; i < 5; i++) send_beat($urandom);
    enable = 1'b0;
    for (int i = 0; i < 11; i++) send_beat($urandom);
    wait_drain();
    repeat (2) @(posedge aclk);
    #1;
    check("stop_busy_at_last", busy_at_last, 1'b1);
    check("stop_busy_low", busy, 1'b0);
    check("stop_s_tready_idle", S_AXIS_tready, 1'b1);
    check("stop_frame_count", frame_count, 32'd1);
    keep = 1'b0;
    for (int i = 0; i < 8; i++) send_beat($urandom);
    repeat (3) @(posedge aclk);
    #1;
    check("stop_idle_frame_count", frame_count, 32'd1);
    keep = 1'b1;
    chk_ready = 1'b1;

    // Length change mid-frame: current frame keeps 2, next frame is 8.
    do_reset();
    log_frame_length = 5'd1;
    start_run();
    send_beat($urandom);
    log_frame_length = 5'd3;
    send_beat($urandom);
    repeat (2) @(posedge aclk);
    #1;
    check("len_first_frame", frame_count, 32'd1);
    for (int i = 0; i < 8; i++) send_beat($urandom);
    wait_drain();
    check("len_frame_count", frame_count, 32'd2);

    // log_frame_length = 0: every beat is a frame.
    do_reset();
    log_frame_length = 5'd0;
    start_run();
    for (int i = 0; i < 10; i++) send_beat($urandom);
    wait_drain();
    check("log0_frame_count", frame_count, 32'd10);

    // Reset with both buffer entries full, then restart from index 0.
    do_reset();
    log_frame_length = 5'd2;
    start_run();
    for (int i = 0; i < 4; i++) send_beat($urandom);
    wait_drain();
    check("rstmid_pre_count", frame_count, 32'd1);
    m_ready_dir = 1'b0;
    @(posedge aclk);
    #1;
    send_beat($urandom);
    send_beat($urandom);
    @(negedge aclk);
    check("rstmid_full_s_tready", S_AXIS_tready, 1'b0);
    check("rstmid_full_m_tvalid", M_AXIS_tvalid, 1'b1);
    #2;
    areset = 1'b1;
    #1;
    check("rstmid_async_m_tvalid", M_AXIS_tvalid, 1'b0);
    check("rstmid_async_count", frame_count, 32'd0);
    check("rstmid_async_busy", busy, 1'b0);
    m_ready_dir = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    @(posedge aclk);
    #1;
    for (int i = 0; i < 4; i++) send_beat($urandom);
    wait_drain();
    check("rstmid_restart_count", frame_count, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
